// File: rtl/outport_vc_allocator_pkg.sv
// outport_vc_allocator_pkg: shared defaults and FSM state encoding for the outport VC allocator
package outport_vc_allocator_pkg;
  localparam int def_no_inport = 6;
  localparam int def_no_vc = 13;
  localparam int def_vc_w = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, COOL = 2'd2} state_t;
endpackage

// File: rtl/outport_vc_allocator_if.sv
// outport_vc_allocator_if: request/grant/release bundle between input ports and one outport allocator
interface outport_vc_allocator_if
  import outport_vc_allocator_pkg::*;
#(
  parameter int no_inport = def_no_inport,
  parameter int no_vc = def_no_vc,
  parameter int floorplusone_log2_no_vc = def_vc_w
);
  logic en;
  logic [no_inport-1:0] req_vec;
  logic [no_inport*floorplusone_log2_no_vc-1:0] invc_req_bus;
  logic [no_inport*no_vc-1:0] allow_vcs_bus;
  logic [no_vc-1:0] vc_release;
  logic [no_inport-1:0] ok_vec;
  logic grant_valid;
  logic [floorplusone_log2_no_vc-1:0] grant_vc;
  logic [floorplusone_log2_no_vc-1:0] grant_invc;
  logic [no_vc-1:0] vc_busy;
  logic no_free_vc;
  modport master (
    output en, req_vec, invc_req_bus, allow_vcs_bus, vc_release,
    input ok_vec, grant_valid, grant_vc, grant_invc, vc_busy, no_free_vc
  );
  modport slave (
    input en, req_vec, invc_req_bus, allow_vcs_bus, vc_release,
    output ok_vec, grant_valid, grant_vc, grant_invc, vc_busy, no_free_vc
  );
endinterface

// File: rtl/outport_vc_allocator_rr_arbiter.sv
// outport_vc_allocator_rr_arbiter: round-robin pick of the first request at or above ptr, wrapping
module outport_vc_allocator_rr_arbiter #(
  parameter int n = 6,
  localparam int pw = $clog2(n)
) (
  input  logic [n-1:0]  req,
  input  logic [pw-1:0] ptr,
  output logic [n-1:0]  gnt,
  output logic [pw-1:0] idx,
  output logic          any
);
  logic [2*n-1:0] dbl;
  logic [n-1:0] rot;
  int pos;
  // rotate so that bit 0 of rot is the request at ptr
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[n-1:0];
  always_comb begin
    pos = 0;
    for (int k = n-1; k >= 0; k--) if (rot[k]) pos = k;
  end
  assign idx = pw'((int'(ptr) + pos) % n);
  assign any = |req;
  assign gnt = any ? n'(1) << idx : '0;
endmodule

// File: rtl/outport_vc_allocator.sv
// outport_vc_allocator: round-robin grants of free downstream VCs to requesting input ports,
// with a GRANT/COOL hold after each grant and per-VC busy tracking until release.
module outport_vc_allocator
  import outport_vc_allocator_pkg::*;
#(
  parameter int no_inport = def_no_inport,
  parameter int no_vc = def_no_vc,
  parameter int floorplusone_log2_no_vc = def_vc_w
) (
  input logic clk,
  input logic reset,
  outport_vc_allocator_if.slave vif
);
  localparam int vw = floorplusone_log2_no_vc;
  localparam int pw = $clog2(no_inport);
  state_t state, state_nx;
  logic [pw-1:0] rr_ptr, win;
  logic [no_inport-1:0] elig, gnt, ok;
  logic [no_vc-1:0] allow [no_inport];
  logic [vw-1:0] invc [no_inport];
  logic [no_vc-1:0] busy, set_mask;
  logic [vw-1:0] pick, gvc, ginvc;
  logic any, fire, gv;
  function automatic logic [vw-1:0] first_free(input logic [no_vc-1:0] m);
    first_free = '0;
    for (int v = no_vc-1; v >= 0; v--) if (m[v]) first_free = vw'(v);
  endfunction
  for (genvar i = 0; i < no_inport; i++) begin : g_field
    assign allow[i] = vif.allow_vcs_bus[i*no_vc +: no_vc];
    assign invc[i] = vif.invc_req_bus[i*vw +: vw];
    assign elig[i] = vif.req_vec[i] & |(allow[i] & ~busy);
  end
  outport_vc_allocator_rr_arbiter #(.n(no_inport)) u_arb (
    .req(elig), .ptr(rr_ptr), .gnt(gnt), .idx(win), .any(any)
  );
  assign pick = first_free(allow[win] & ~busy);
  assign fire = (state == IDLE) && vif.en && any;
  assign set_mask = fire ? no_vc'(1) << pick : '0;
  always_comb begin
    state_nx = state == IDLE ? (fire ? GRANT : IDLE) : state == GRANT ? COOL : IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      ok <= '0;
      gv <= 1'b0;
      gvc <= '0;
      ginvc <= '0;
      busy <= '0;
    end else begin
      state <= state_nx;
      // release uses the pre-edge mask for arbitration; a newly granted VC is never the released one
      busy <= (busy & ~vif.vc_release) | set_mask;
      if (fire) begin
        ok <= gnt;
        gv <= 1'b1;
        gvc <= pick;
        ginvc <= invc[win];
        rr_ptr <= (win == pw'(no_inport-1)) ? '0 : win + 1'b1;
      end else if (state == GRANT) begin
        ok <= '0;
        gv <= 1'b0;
        gvc <= '0;
        ginvc <= '0;
      end
    end
  end
  assign vif.ok_vec = ok;
  assign vif.grant_valid = gv;
  assign vif.grant_vc = gvc;
  assign vif.grant_invc = ginvc;
  assign vif.vc_busy = busy;
  assign vif.no_free_vc = &busy;
endmodule

// File: tb/tb_outport_vc_allocator.sv
// tb_outport_vc_allocator: directed vectors with hand-computed grants for the outport VC allocator
module tb_outport_vc_allocator;
  logic clk = 1'b0;
  logic reset;
  logic [12:0] allow [6];
  logic [3:0] invc [6];
  int total = 0;
  int bad = 0;
  outport_vc_allocator_if bus();
  outport_vc_allocator dut (.clk(clk), .reset(reset), .vif(bus));
  always #5 clk = ~clk;
  for (genvar g = 0; g < 6; g++) begin : g_pack
    assign bus.allow_vcs_bus[g*13 +: 13] = allow[g];
    assign bus.invc_req_bus[g*4 +: 4] = invc[g];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask
  initial begin
    reset = 1'b0;
    bus.en = 1'b0;
    bus.req_vec = '0;
    bus.vc_release = '0;
    for (int i = 0; i < 6; i++) begin
      allow[i] = '0;
      invc[i] = '0;
    end
    #6;
    chk("rst_ok", bus.ok_vec, 0);
    chk("rst_gv", bus.grant_valid, 0);
    chk("rst_busy", bus.vc_busy, 0);
    chk("rst_nofree", bus.no_free_vc, 0);
    step();
    reset = 1'b1;
    // single request
    bus.en = 1'b1;
    bus.req_vec = 6'b000001;
    allow[0] = 13'h0003;
    invc[0] = 4'd2;
    step();
    chk("t1_ok", bus.ok_vec, 6'b000001);
    chk("t1_gv", bus.grant_valid, 1);
    chk("t1_vc", bus.grant_vc, 0);
    chk("t1_invc", bus.grant_invc, 2);
    chk("t1_busy", bus.vc_busy, 13'h0001);
    bus.req_vec = '0;
    step();
    chk("t1_clr_ok", bus.ok_vec, 0);
    chk("t1_clr_gv", bus.grant_valid, 0);
    chk("t1_hold_busy", bus.vc_busy, 13'h0001);
    step();
    bus.vc_release = 13'h0001;
    step();
    bus.vc_release = '0;
    chk("t1_rel_busy", bus.vc_busy, 0);
    // round-robin fairness
    do_reset();
    allow[0] = 13'h1fff;
    allow[2] = 13'h1fff;
    invc[0] = 4'd1;
    invc[2] = 4'd5;
    bus.req_vec = 6'b000101;
    step();
    chk("t2_g0_ok", bus.ok_vec, 6'b000001);
    chk("t2_g0_vc", bus.grant_vc, 0);
    chk("t2_g0_invc", bus.grant_invc, 1);
    step();
    chk("t2_gap1", bus.ok_vec, 0);
    step();
    chk("t2_gap2", bus.ok_vec, 0);
    step();
    chk("t2_g1_ok", bus.ok_vec, 6'b000100);
    chk("t2_g1_vc", bus.grant_vc, 1);
    chk("t2_g1_invc", bus.grant_invc, 5);
    step();
    step();
    step();
    chk("t2_g2_ok", bus.ok_vec, 6'b000001);
    chk("t2_g2_vc", bus.grant_vc, 2);
    chk("t2_busy", bus.vc_busy, 13'h0007);
    bus.req_vec = '0;
    bus.vc_release = 13'h1fff;
    step();
    bus.vc_release = '0;
    chk("t2_rel_busy", bus.vc_busy, 0);
    step();
    // exhaustion and release timing
    allow[0] = 13'h0001;
    allow[2] = '0;
    invc[0] = 4'd3;
    bus.req_vec = 6'b000001;
    step();
    chk("t3_first_ok", bus.ok_vec, 6'b000001);
    step();
    step();
    step();
    step();
    chk("t3_blocked_ok", bus.ok_vec, 0);
    chk("t3_nofree", bus.no_free_vc, 0);
    bus.vc_release = 13'h0001;
    step();
    bus.vc_release = '0;
    chk("t3_reledge_ok", bus.ok_vec, 0);
    chk("t3_reledge_busy", bus.vc_busy, 0);
    step();
    chk("t3_ok", bus.ok_vec, 6'b000001);
    chk("t3_vc", bus.grant_vc, 0);
    bus.req_vec = '0;
    step();
    step();
    // fill every VC, then one release
    do_reset();
    for (int i = 0; i < 6; i++) allow[i] = 13'h1fff;
    bus.req_vec = 6'b111111;
    for (int v = 0; v < 13; v++) begin
      step();
      chk("full_ok", bus.ok_vec, 1 << (v % 6));
      chk("full_vc", bus.grant_vc, v);
      step();
      step();
    end
    chk("full_nofree", bus.no_free_vc, 1);
    chk("full_busy", bus.vc_busy, 13'h1fff);
    step();
    step();
    chk("full_noGrant", bus.ok_vec, 0);
    bus.vc_release = 13'h0020;
    step();
    bus.vc_release = '0;
    chk("full_relhold", bus.ok_vec, 0);
    step();
    chk("full_rel_ok", bus.ok_vec, 6'b000010);
    chk("full_rel_vc", bus.grant_vc, 5);
    bus.req_vec = '0;
    step();
    step();
    // skip ineligible inport
    do_reset();
    for (int i = 0; i < 6; i++) allow[i] = '0;
    allow[5] = 13'h0001;
    bus.req_vec = 6'b100000;
    step();
    chk("t4_pre_ok", bus.ok_vec, 6'b100000);
    bus.req_vec = '0;
    step();
    step();
    allow[0] = 13'h0001;
    allow[3] = 13'h0002;
    invc[3] = 4'd7;
    bus.req_vec = 6'b001001;
    step();
    chk("t4_ok", bus.ok_vec, 6'b001000);
    chk("t4_vc", bus.grant_vc, 1);
    chk("t4_invc", bus.grant_invc, 7);
    allow[0] = 13'h1fff;
    allow[4] = 13'h1fff;
    bus.req_vec = 6'b010001;
    step();
    step();
    step();
    chk("t4_ptr_ok", bus.ok_vec, 6'b010000);
    chk("t4_ptr_vc", bus.grant_vc, 2);
    // enable gating
    bus.en = 1'b0;
    bus.req_vec = 6'b000010;
    allow[1] = 13'h1fff;
    step();
    step();
    step();
    step();
    chk("t5_hold_ok", bus.ok_vec, 0);
    chk("t5_hold_gv", bus.grant_valid, 0);
    bus.en = 1'b1;
    step();
    chk("t5_ok", bus.ok_vec, 6'b000010);
    chk("t5_vc", bus.grant_vc, 3);
    // asynchronous reset in the middle of GRANT
    #2;
    reset = 1'b0;
    #1;
    chk("t6_ok", bus.ok_vec, 0);
    chk("t6_gv", bus.grant_valid, 0);
    chk("t6_busy", bus.vc_busy, 0);
    step();
    reset = 1'b1;
    bus.req_vec = 6'b000011;
    allow[0] = 13'h1fff;
    step();
    chk("t6_first_ok", bus.ok_vec, 6'b000001);
    chk("t6_first_vc", bus.grant_vc, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
